pwm_multi_phy: RTL and testbench

Parametrised multi-channel successor to the single-channel PWM PHY. A single-clock, FIFO-fed command queue updates per-channel period and duty. Each channel double-buffers its settings, so updates only take effect at that channel's period boundary. Outputs are glitch-free. The block sits between the register/bridge write path and the pads, and drives `NUM_CH` PWM pins from one shared prescaler.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_channel.sv | 130 +++++++++++++
 rtl/pwm_multi_phy.sv | 107 ++++++++++
 tb/tb_pwm_multi_phy.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared mode type and command-word layout helpers for pwm_multi_phy.
// Word layout, LSB first: duty, period, ch_idx, then a mode bit when PWM_CENTER_ALIGN_EN is defined.
package pwm_pkg;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int period_lsb(input int cnt_w);
        return cnt_w;
    endfunction

    function automatic int ch_lsb(input int cnt_w);
        return 2 * cnt_w;
    endfunction

    function automatic int calc_cmd_w(input int num_ch, input int cnt_w);
`ifdef PWM_CENTER_ALIGN_EN
        return calc_ch_w(num_ch) + 2 * cnt_w + 1;
`else
        return calc_ch_w(num_ch) + 2 * cnt_w;
`endif
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active settings, period counter, compare and output flop (PWM_CENTER_ALIGN_EN adds up/down mode).
// Latency: shadow write -> active load next boundary (next clock when idle) -> output one clock later; no backpressure.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_tick,
    input  logic                 i_wr,
    input  logic [CNT_WIDTH-1:0] i_period,
    input  logic [CNT_WIDTH-1:0] i_duty,
`ifdef PWM_CENTER_ALIGN_EN
    input  pwm_mode_e            i_mode,
`endif
    output logic                 o_pwm,
    output logic                 o_tick
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_period_sh, r_duty_sh, r_period_act, r_duty_act, r_cnt;
    logic                 r_pending, r_pwm, r_tick;
    logic [CNT_WIDTH-1:0] w_cnt_nxt, w_last;
    logic                 w_idle, w_bnd, w_load;
`ifdef PWM_CENTER_ALIGN_EN
    pwm_mode_e            r_mode_sh, r_mode_act;
    logic                 r_down, w_down_nxt;
`endif

    // Disabled channels behave as idle so pending settings land immediately.
    assign w_idle = !i_en || (r_period_act == '0);
    assign w_last = r_period_act - ONE;
    assign w_load = r_pending && (w_idle || w_bnd);
    assign o_pwm  = r_pwm;
    assign o_tick = r_tick;

    always_comb begin
        w_bnd     = 1'b0;
        w_cnt_nxt = r_cnt;
`ifdef PWM_CENTER_ALIGN_EN
        w_down_nxt = r_down;
`endif
        if (w_idle) begin
            w_cnt_nxt = '0;
`ifdef PWM_CENTER_ALIGN_EN
            w_down_nxt = 1'b0;
`endif
        end else if (i_tick) begin
`ifdef PWM_CENTER_ALIGN_EN
            if (r_mode_act == CENTER) begin
                // Up to period-1, then down; the step back to 0 is the boundary.
                if (!r_down && r_cnt != w_last) begin
                    w_cnt_nxt = r_cnt + ONE;
                end else if (r_cnt <= ONE) begin
                    w_bnd      = 1'b1;
                    w_cnt_nxt  = '0;
                    w_down_nxt = 1'b0;
                end else begin
                    w_cnt_nxt  = r_cnt - ONE;
                    w_down_nxt = 1'b1;
                end
            end else if (r_cnt == w_last) begin
                w_bnd     = 1'b1;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
`else
            if (r_cnt == w_last) begin
                w_bnd     = 1'b1;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_sh  <= '0;
            r_duty_sh    <= '0;
            r_period_act <= '0;
            r_duty_act   <= '0;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_pwm        <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            if (i_wr) begin
                r_period_sh <= i_period;
                r_duty_sh   <= i_duty;
            end
            r_pending <= i_wr || (r_pending && !w_load);
            r_tick    <= w_load;
            r_pwm     <= !w_idle && (r_cnt < r_duty_act);
            if (w_load) begin
                r_period_act <= r_period_sh;
                r_duty_act   <= r_duty_sh;
                r_cnt        <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_sh  <= EDGE;
            r_mode_act <= EDGE;
            r_down     <= 1'b0;
        end else begin
            if (i_wr) begin
                r_mode_sh <= i_mode;
            end
            if (w_load) begin
                r_mode_act <= r_mode_sh;
                r_down     <= 1'b0;
            end else begin
                r_down <= w_down_nxt;
            end
        end
    end
`endif

endmodule

// File: rtl/pwm_multi_phy.sv
// NUM_CH-channel PWM PHY fed by a command FIFO and one shared prescaler; PWM_CENTER_ALIGN_EN enables up/down mode.
// Latency: write -> pop next clock -> idle-channel load the clock after; full FIFO drops writes and sets sticky ovf_err.
module pwm_multi_phy
    import pwm_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int CNT_WIDTH  = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int CH_W       = calc_ch_w(NUM_CH),
    localparam int CMD_W      = calc_cmd_w(NUM_CH, CNT_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [7:0]        cfg_prescale,
    input  logic              wr_en,
    input  logic [CMD_W-1:0]  wr_data,
    input  logic              test_drain_hold,
    output logic              fifo_full,
    output logic              ovf_err,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] period_tick
);

    localparam int           AW      = $clog2(FIFO_DEPTH);
    localparam int           PER_LSB = period_lsb(CNT_WIDTH);
    localparam int           CH_LSB  = ch_lsb(CNT_WIDTH);
    localparam logic [AW:0]  FULL_V  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]  CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic [7:0]       r_ps;
    logic             w_empty, w_pop, w_push, w_tick;
    logic [CMD_W-1:0] w_head;
    logic [CH_W-1:0]  w_ch;

    // test_drain_hold only exists so the FIFO can be filled; tie low in service.
    assign fifo_full = (r_count == FULL_V);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && !test_drain_hold;
    assign w_push    = wr_en && (!fifo_full || w_pop);
    assign ovf_err   = r_ovf;
    assign w_tick    = cfg_en && (r_ps == cfg_prescale);
    assign w_head    = r_mem[r_rptr];
    assign w_ch      = w_head[CH_LSB +: CH_W];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ps    <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_en && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (!cfg_en || r_ps == cfg_prescale) begin
                r_ps <= '0;
            end else begin
                r_ps <= r_ps + 8'd1;
            end
        end
    end

    // Entries whose ch_idx matches no channel are popped with no effect.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (cfg_en),
            .i_tick   (w_tick),
            .i_wr     (w_pop && (w_ch == CH_W'(g))),
            .i_period (w_head[PER_LSB +: CNT_WIDTH]),
            .i_duty   (w_head[0 +: CNT_WIDTH]),
`ifdef PWM_CENTER_ALIGN_EN
            .i_mode   (pwm_mode_e'(w_head[CMD_W-1])),
`endif
            .o_pwm    (pwm_out[g]),
            .o_tick   (period_tick[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_phy.sv
// Self-checking bench for pwm_multi_phy against a closed-form waveform model.
// Waveform expectation after a phase-aligned start: high when floor(j/(ps+1)) mod period < duty.
module tb_pwm_multi_phy;

    localparam int NCH  = 4;
    localparam int CW   = 16;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int CMDW = 2 + 2 * CW + 1;
`else
    localparam int CMDW = 2 + 2 * CW;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_en;
    logic [7:0]      cfg_prescale;
    logic            wr_en;
    logic [CMDW-1:0] wr_data;
    logic            test_drain_hold;
    logic            fifo_full;
    logic            ovf_err;
    logic [NCH-1:0]  pwm_out;
    logic [NCH-1:0]  period_tick;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_p [NCH];
    int exp_d [NCH];

    pwm_multi_phy #(
        .NUM_CH     (NCH),
        .CNT_WIDTH  (CW),
        .FIFO_DEPTH (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_en          (cfg_en),
        .cfg_prescale    (cfg_prescale),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .test_drain_hold (test_drain_hold),
        .fifo_full       (fifo_full),
        .ovf_err         (ovf_err),
        .pwm_out         (pwm_out),
        .period_tick     (period_tick)
    );

    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CMDW-1:0] mk_cmd(input int ch, input int p, input int d);
        logic [CMDW-1:0] w;
        w = '0;
        w[2*CW +: 2] = 2'(ch);
        w[CW +: CW]  = CW'(p);
        w[0 +: CW]   = CW'(d);
        return w;
    endfunction

    function automatic logic model_pwm(input int j, input int ps, input int p, input int d);
        if (p == 0) return 1'b0;
        return ((j / (ps + 1)) % p) < d;
    endfunction

    task automatic drive_cmd(input int ch, input int p, input int d);
        wr_en   = 1'b1;
        wr_data = mk_cmd(ch, p, d);
        tick_clk();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        cfg_en          = 1'b0;
        cfg_prescale    = 8'd0;
        wr_en           = 1'b0;
        wr_data         = '0;
        test_drain_hold = 1'b0;
        tick_clk();
        tick_clk();
        rst_n = 1'b1;
        tick_clk();
    endtask

    // Loads exp_p/exp_d into every channel while cfg_en is low.
    task automatic load_all();
        int cnt [NCH];
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        for (int c = 0; c < NCH; c++) begin
            drive_cmd(c, exp_p[c], exp_d[c]);
            for (int k = 0; k < NCH; k++) cnt[k] += int'(period_tick[k]);
        end
        repeat (6) begin
            tick_clk();
            for (int k = 0; k < NCH; k++) cnt[k] += int'(period_tick[k]);
        end
        for (int c = 0; c < NCH; c++) begin
            if (exp_p[c] != 0) begin
                n_chk++;
                if (cnt[c] !== 1) $display("FAIL load_tick_count ch=%0d got=%0d exp=1", c, cnt[c]);
                else n_pass++;
            end
        end
    endtask

    task automatic run_aligned(input int ps, input int ncyc);
        logic [NCH-1:0] e;
        cfg_prescale = 8'(ps);
        cfg_en       = 1'b1;
        for (int j = 0; j < ncyc; j++) begin
            tick_clk();
            for (int c = 0; c < NCH; c++) e[c] = model_pwm(j, ps, exp_p[c], exp_d[c]);
            n_chk++;
            if (pwm_out !== e) $display("FAIL aligned_pwm j=%0d ps=%0d got=%b exp=%b", j, ps, pwm_out, e);
            else n_pass++;
            n_chk++;
            if (period_tick !== '0) $display("FAIL aligned_tick j=%0d got=%b exp=0000", j, period_tick);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        cfg_en          = 1'b1;
        cfg_prescale    = 8'd0;
        wr_en           = 1'b1;
        wr_data         = mk_cmd(0, 4, 2);
        test_drain_hold = 1'b0;
        tick_clk();
        tick_clk();
        n_chk++;
        if ({fifo_full, ovf_err, pwm_out, period_tick} !== '0)
            $display("FAIL reset_outputs got=%b%b_%b_%b exp=all zero", fifo_full, ovf_err, pwm_out, period_tick);
        else n_pass++;
        do_reset();
        n_chk++;
        if ({fifo_full, ovf_err, pwm_out, period_tick} !== '0)
            $display("FAIL reset_release got=%b%b_%b_%b exp=all zero", fifo_full, ovf_err, pwm_out, period_tick);
        else n_pass++;
    endtask

    task automatic test_first_load();
        logic [NCH-1:0] e_pwm, e_tick;
        do_reset();
        cfg_en = 1'b1;
        drive_cmd(0, 10, 3);
        for (int t = 1; t <= 32; t++) begin
            tick_clk();
            e_tick = '0;
            e_pwm  = '0;
            e_tick[0] = (t == 2);
            e_pwm[0]  = (t >= 3) && (((t - 3) % 10) < 3);
            n_chk++;
            if (period_tick !== e_tick) $display("FAIL first_load_tick t=%0d got=%b exp=%b", t, period_tick, e_tick);
            else n_pass++;
            n_chk++;
            if (pwm_out !== e_pwm) $display("FAIL first_load_pwm t=%0d got=%b exp=%b", t, pwm_out, e_pwm);
            else n_pass++;
        end
    endtask

    task automatic test_midperiod_update();
        logic [NCH-1:0] e_pwm, e_tick;
        int w, b;
        do_reset();
        cfg_en = 1'b1;
        w = $urandom_range(5, 18);
        b = 12;
        while (b < w + 2) b += 10;
        drive_cmd(1, 10, 5);
        for (int t = 1; t <= b + 45; t++) begin
            if (t == w) begin
                wr_en   = 1'b1;
                wr_data = mk_cmd(1, 20, 15);
            end
            tick_clk();
            wr_en  = 1'b0;
            e_tick = '0;
            e_pwm  = '0;
            e_tick[1] = (t == 2) || (t == b);
            if (t >= 3 && t <= b) e_pwm[1] = ((t - 3) % 10) < 5;
            else if (t > b)       e_pwm[1] = ((t - 1 - b) % 20) < 15;
            n_chk++;
            if (period_tick !== e_tick) $display("FAIL update_tick t=%0d w=%0d got=%b exp=%b", t, w, period_tick, e_tick);
            else n_pass++;
            n_chk++;
            if (pwm_out !== e_pwm) $display("FAIL update_pwm t=%0d w=%0d got=%b exp=%b", t, w, pwm_out, e_pwm);
            else n_pass++;
        end
    endtask

    task automatic test_edge_cases();
        do_reset();
        exp_p[0] = 7; exp_d[0] = 0;
        exp_p[1] = 5; exp_d[1] = 5;
        exp_p[2] = 0; exp_d[2] = 3;
        exp_p[3] = 4; exp_d[3] = 9;
        load_all();
        run_aligned(0, 30);
    endtask

    task automatic test_prescale_enable();
        do_reset();
        exp_p[0] = 4; exp_d[0] = 2;
        for (int c = 1; c < NCH; c++) begin
            exp_p[c] = $urandom_range(1, 8);
            exp_d[c] = $urandom_range(0, exp_p[c] + 1);
        end
        load_all();
        run_aligned(3, 34);
        cfg_en = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick_clk();
            n_chk++;
            if (pwm_out !== '0 || period_tick !== '0)
                $display("FAIL disable_low t=%0d got=%b/%b exp=0000/0000", t, pwm_out, period_tick);
            else n_pass++;
        end
        run_aligned(3, 20);
    endtask

    task automatic test_overflow();
        int ep [10];
        int ed [10];
        do_reset();
        test_drain_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ep[i] = $urandom_range(1, 12);
            ed[i] = $urandom_range(0, ep[i] + 2);
        end
        for (int i = 0; i < 8; i++) begin
            drive_cmd(i % NCH, ep[i], ed[i]);
            n_chk++;
            if (fifo_full !== (i == 7)) $display("FAIL fill_full i=%0d got=%b exp=%b", i, fifo_full, (i == 7));
            else n_pass++;
            n_chk++;
            if (ovf_err !== 1'b0) $display("FAIL fill_ovf i=%0d got=%b exp=0", i, ovf_err);
            else n_pass++;
        end
        test_drain_hold = 1'b0;
        drive_cmd(3, ep[8], ed[8]);
        test_drain_hold = 1'b1;
        n_chk++;
        if (fifo_full !== 1'b1 || ovf_err !== 1'b0)
            $display("FAIL push_pop_full got=full %b ovf %b exp=full 1 ovf 0", fifo_full, ovf_err);
        else n_pass++;
        drive_cmd(3, ep[9] + 20, ed[9]);
        n_chk++;
        if (fifo_full !== 1'b1 || ovf_err !== 1'b1)
            $display("FAIL drop_ninth got=full %b ovf %b exp=full 1 ovf 1", fifo_full, ovf_err);
        else n_pass++;
        test_drain_hold = 1'b0;
        repeat (14) tick_clk();
        n_chk++;
        if (fifo_full !== 1'b0 || ovf_err !== 1'b1)
            $display("FAIL after_drain got=full %b ovf %b exp=full 0 ovf 1", fifo_full, ovf_err);
        else n_pass++;
        exp_p[0] = ep[4]; exp_d[0] = ed[4];
        exp_p[1] = ep[5]; exp_d[1] = ed[5];
        exp_p[2] = ep[6]; exp_d[2] = ed[6];
        exp_p[3] = ep[8]; exp_d[3] = ed[8];
        run_aligned($urandom_range(0, 2), 30);
        n_chk++;
        if (ovf_err !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", ovf_err);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        test_drain_hold = 1'b1;
        drive_cmd(0, 6, 3);
        drive_cmd(1, 5, 2);
        drive_cmd(2, 4, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({fifo_full, ovf_err, pwm_out, period_tick} !== '0)
            $display("FAIL async_reset got=%b%b_%b_%b exp=all zero", fifo_full, ovf_err, pwm_out, period_tick);
        else n_pass++;
        tick_clk();
        rst_n           = 1'b1;
        test_drain_hold = 1'b0;
        cfg_en          = 1'b1;
        cfg_prescale    = 8'd0;
        for (int t = 0; t < 20; t++) begin
            tick_clk();
            n_chk++;
            if (pwm_out !== '0 || period_tick !== '0 || fifo_full !== 1'b0)
                $display("FAIL queue_cleared t=%0d got=%b/%b/%b exp=0000/0000/0", t, pwm_out, period_tick, fifo_full);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            do_reset();
            for (int c = 0; c < NCH; c++) begin
                exp_p[c] = $urandom_range(0, 15);
                exp_d[c] = $urandom_range(0, exp_p[c] + 2);
            end
            load_all();
            run_aligned($urandom_range(0, 3), 40);
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_midperiod_update();
        test_edge_cases();
        test_prescale_enable();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
